// File: rtl/fe_fifo_decoder_pkg.sv
// Shared front-end sniff FIFO entry layout, used by both the capture writer and the decoder.
// Field positions and command codes must stay identical on both sides of the FIFO.
package fe_fifo_decoder_pkg;

    typedef enum logic [1:0] {
        CMD_DATA = 2'd0,
        CMD_TIME = 2'd1,
        CMD_STAT = 2'd2,
        CMD_RSVD = 2'd3
    } fe_cmd_e;

    localparam int unsigned FE_ENTRY_WIDTH    = 18;
    localparam int unsigned FE_CMD_START      = 0;
    localparam int unsigned FE_CMD_LEN        = 2;
    localparam int unsigned FE_TIME_START     = 2;
    localparam int unsigned FE_TIME_SHORT_LEN = 3;
    localparam int unsigned FE_TIME_FULL_LEN  = 16;
    localparam int unsigned FE_DATA_START     = 5;
    localparam int unsigned FE_DATA_LEN       = 8;
    localparam int unsigned FE_STATUS_START   = 13;
    localparam int unsigned FE_STATUS_LEN     = 5;

    // Bit positions inside the status field
    localparam int unsigned FE_STAT_VBUSVLD   = 0;
    localparam int unsigned FE_STAT_SESSEND   = 1;
    localparam int unsigned FE_STAT_SESSVLD   = 2;
    localparam int unsigned FE_STAT_RXERROR   = 3;
    localparam int unsigned FE_STAT_RXACTIVE  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2
    } dec_state_e;

endpackage

// File: rtl/fe_fifo_decoder.sv
// Read side of the front-end sniff FIFO: pops entries, rebuilds absolute timestamps
// from per-entry deltas and presents DATA/STAT records over a valid/ready handshake.
module fe_fifo_decoder
    import fe_fifo_decoder_pkg::*;
#(
    parameter int unsigned pTIMESTAMP_FULL_WIDTH  = 16,
    parameter int unsigned pTIMESTAMP_SHORT_WIDTH = 3,
    parameter int unsigned pACC_WIDTH             = 32,
    parameter int unsigned pCOUNT_WIDTH           = 24
) (
    input  logic                    cwusb_clk,
    input  logic                    reset_n,
    input  logic                    I_clear,
    input  logic                    I_fifo_empty,
    input  logic [17:0]             I_fifo_dout,
    output logic                    O_fifo_rd,
    output logic                    O_valid,
    input  logic                    I_ready,
    output logic                    O_is_data,
    output logic [7:0]              O_data,
    output logic [4:0]              O_status,
    output logic [pACC_WIDTH-1:0]   O_timestamp,
    output logic [pCOUNT_WIDTH-1:0] O_count,
    output logic                    O_error
);

    localparam logic [pCOUNT_WIDTH-1:0] CNT_ONE = 1;

    dec_state_e                state_q, state_d;
    logic [pACC_WIDTH-1:0]     acc_q, acc_d;
    logic [pACC_WIDTH-1:0]     ts_q, ts_d;
    logic [pCOUNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic                      is_data_q, is_data_d;
    logic [7:0]                data_q, data_d;
    logic [4:0]                status_q, status_d;
    logic                      rd_d;

    fe_cmd_e                   cmd;
    logic [pACC_WIDTH-1:0]     delta;
    logic [pACC_WIDTH-1:0]     acc_sum;

    assign cmd = fe_cmd_e'(I_fifo_dout[FE_CMD_START +: FE_CMD_LEN]);

    always_comb begin
        delta = '0;
        if (cmd == CMD_TIME) begin
            delta[pTIMESTAMP_FULL_WIDTH-1:0] = I_fifo_dout[FE_TIME_START +: pTIMESTAMP_FULL_WIDTH];
        end else begin
            delta[pTIMESTAMP_SHORT_WIDTH-1:0] = I_fifo_dout[FE_TIME_START +: pTIMESTAMP_SHORT_WIDTH];
        end
    end

    assign acc_sum = acc_q + delta;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ts_d      = ts_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        is_data_d = is_data_q;
        data_d    = data_q;
        status_d  = status_q;
        rd_d      = 1'b0;

        if (I_clear) begin
            state_d   = ST_IDLE;
            acc_d     = '0;
            ts_d      = '0;
            cnt_d     = '0;
            err_d     = 1'b0;
            is_data_d = 1'b0;
            data_d    = '0;
            status_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!I_fifo_empty) begin
                        rd_d    = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    unique case (cmd)
                        CMD_DATA, CMD_STAT: begin
                            acc_d     = acc_sum;
                            ts_d      = acc_sum;
                            is_data_d = (cmd == CMD_DATA);
                            data_d    = (cmd == CMD_DATA) ? I_fifo_dout[FE_DATA_START +: FE_DATA_LEN] : '0;
                            status_d  = I_fifo_dout[FE_STATUS_START +: FE_STATUS_LEN];
                            state_d   = ST_OUT;
                        end
                        CMD_TIME: begin
                            acc_d   = acc_sum;
                            state_d = ST_IDLE;
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    endcase
                end
                ST_OUT: begin
                    // Accepting a record with more data queued issues the next read at once
                    if (I_ready) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (!I_fifo_empty) begin
                            rd_d    = 1'b1;
                            state_d = ST_WAIT;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge cwusb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            ts_q      <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            is_data_q <= 1'b0;
            data_q    <= '0;
            status_q  <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ts_q      <= ts_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            is_data_q <= is_data_d;
            data_q    <= data_d;
            status_q  <= status_d;
        end
    end

    // Read strobe is combinational from IDLE/OUT, so hold it off while reset is asserted
    assign O_fifo_rd   = rd_d & reset_n;
    assign O_valid     = (state_q == ST_OUT);
    assign O_is_data   = is_data_q;
    assign O_data      = data_q;
    assign O_status    = status_q;
    assign O_timestamp = ts_q;
    assign O_count     = cnt_q;
    assign O_error     = err_q;

endmodule

// File: doc/fe_fifo_decoder.md
Name: fe_fifo_decoder

Overview:
- Read-side counterpart of the front-end capture FIFO writer, in the cwusb_clk domain.
- Pops packed 18-bit sniff FIFO entries and decodes the command field (DATA/STAT/TIME).
- Rebuilds absolute timestamps from per-entry time deltas.
- Presents one decoded record per valid/ready handshake to the downstream readback/trigger logic.

Parameters:
- pTIMESTAMP_FULL_WIDTH, 16, width of the TIME-entry delta field.
- pTIMESTAMP_SHORT_WIDTH, 3, width of the DATA/STAT delta field.
- pACC_WIDTH, 32, absolute timestamp accumulator width; must be greater than pTIMESTAMP_FULL_WIDTH.
- pCOUNT_WIDTH, 24, emitted-record counter width.

Ports:
- cwusb_clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- I_clear  in  1  synchronous flush: clears the accumulator, counter, error flag and any held record.
- I_fifo_empty  in  1  FIFO empty flag.
- I_fifo_dout  in  18  FIFO read data, valid one cycle after O_fifo_rd (standard-mode FIFO).
- O_fifo_rd  out  1  FIFO read strobe.
- O_valid  out  1  decoded record available.
- I_ready  in  1  downstream accepts the record.
- O_is_data  out  1  1 = DATA record, 0 = STAT record.
- O_data  out  8  USB byte; 0 for STAT.
- O_status  out  5  rxactive/rxerror/sessvld/sessend/vbusvld snapshot.
- O_timestamp  out  pACC_WIDTH  absolute time of the record.
- O_count  out  pCOUNT_WIDTH  records emitted since reset or clear.
- O_error  out  1  sticky: reserved command seen.

Behaviour:
- Entry layout:
  - cmd [1:0]: DATA=0, TIME=1, STAT=2, 3 reserved.
  - DATA/STAT: short delta [4:2], data [12:5], status [17:13].
  - TIME: full delta [17:2].
- Reset (async, reset_n low): state IDLE, O_fifo_rd=0, O_valid=0, O_is_data=0, O_data=0, O_status=0, O_timestamp=0, accumulator=0, O_count=0, O_error=0.
- State IDLE:
  - If I_fifo_empty=0: assert O_fifo_rd for exactly one cycle, go to WAIT.
  - Never read when empty.
- State WAIT (I_fifo_dout now valid): accumulator += zero-extended delta, modulo 2^pACC_WIDTH.
  - DATA/STAT: latch O_is_data/O_data/O_status and O_timestamp = new accumulator value; go to OUT.
  - TIME: no record emitted; go to IDLE.
  - Reserved: set O_error, discard the entry, leave the accumulator unchanged, go to IDLE.
- State OUT:
  - O_valid=1; fields are stable until the handshake.
  - On I_valid & I_ready (O_valid & I_ready): O_count += 1 (wraps), O_valid drops next cycle.
  - Same handshake cycle with I_fifo_empty=0: assert O_fifo_rd and go straight to WAIT (back-to-back, one record per 2 cycles).
  - Same handshake cycle with FIFO empty: go to IDLE.
  - No handshake: stay in OUT; no reads issued.
- Latency: from the O_fifo_rd cycle, O_valid rises 2 cycles later.
- I_clear: highest priority over all state actions.
  - Next state IDLE; O_valid=0; accumulator, O_count and O_error cleared.
  - A read in flight (clear during WAIT) is discarded, and its entry is lost.
  - A record held in OUT is dropped without counting.
  - I_fifo_empty is ignored during the clear cycle.
- Consecutive TIME entries accumulate; the first DATA/STAT after them carries the summed time.
- O_fifo_rd is never asserted while O_valid=1 without a handshake in the same cycle.

Decomposition:
- Shared defines (same file as the writer's field defines):
  - cmd encodings.
  - Field start/length constants for cmd, time, data and status.
  - Status-bit indices.
- Writer and decoder must reference the same constants.
- No sub-module: a single FSM plus accumulator is small enough.

Test Plan:
- DATA entry delta=3, data=0xA5, status=0x01 after reset -> O_valid with O_is_data=1, O_data=0xA5, O_status=0x01, O_timestamp=3, O_count=1 after handshake.
- TIME delta=0xFFFF, then TIME delta=0x0001, then STAT delta=2, status=0x1C -> one record only: O_is_data=0, O_data=0, O_timestamp=0x10002.
- 8 DATA entries pre-loaded, I_ready held 1 -> O_fifo_rd every 2nd cycle, 8 records, timestamps cumulative, O_count=8, no read after empty.
- I_ready held 0 for 10 cycles on a held record -> fields stable, O_fifo_rd=0 throughout; record accepted on release.
- Reserved cmd=3 entry between DATA delta=1 and DATA delta=1 -> O_error=1 sticky, two records with timestamps 1 and 2.
- Async reset_n low during OUT, and separately I_clear during WAIT -> all outputs return to reset values immediately (reset) or next cycle (clear); the next DATA delta=4 gives O_timestamp=4, O_count=1.
